// File: rtl/iterative_divider_nbit.sv
// Restoring N-bit divider (signed/unsigned, RISC-V div-by-zero/overflow rules), one quotient bit per clock;
// DONE N+1 edges after START, START ignored while BUSY. DIV_EARLY_OUT_EN: special cases skip CALC (DONE 1 edge after START).
module iterative_divider_nbit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        state;
  logic [N-1:0]  dvd_q;
  logic [N-1:0]  dsr_q;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  orig_q;
  logic [CW-1:0] cnt_q;
  logic          neg_quo_q;
  logic          neg_rem_q;
  logic          dz_q;
  logic          ovf_q;

  logic          dvd_neg;
  logic          dsr_neg;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dsr_mag;
  logic          sp_dz;
  logic          sp_ovf;
  logic          early;
  logic          accept;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          qbit;

  assign dvd_neg = is_signed & dividend[N-1];
  assign dsr_neg = is_signed & divisor[N-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor : divisor;
  assign sp_dz   = (divisor == '0);
  assign sp_ovf  = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef DIV_EARLY_OUT_EN
  assign early = sp_dz | sp_ovf;
`else
  assign early = 1'b0;
`endif

  // The partial remainder stays below the divisor, so N+1 bits hold the trial difference and its sign.
  assign shifted = {rem_q, dvd_q[N-1]};
  assign trial   = shifted - {1'b0, dsr_q};
  assign qbit    = ~trial[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      orig_q      <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dvd_q     <= dvd_mag;
            dsr_q     <= dsr_mag;
            rem_q     <= '0;
            orig_q    <= dividend;
            cnt_q     <= CW'(N - 1);
            neg_quo_q <= dvd_neg ^ dsr_neg;
            neg_rem_q <= dvd_neg;
            dz_q      <= sp_dz;
            ovf_q     <= sp_ovf;
            busy      <= 1'b1;
            state     <= early ? S_FIX : S_CALC;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q <= qbit ? trial[N-1:0] : shifted[N-1:0];
          dvd_q <= {dvd_q[N-2:0], qbit};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (dz_q) begin
            quotient  <= '1;
            remainder <= orig_q;
          end else if (ovf_q) begin
            quotient  <= orig_q;
            remainder <= '0;
          end else begin
            quotient  <= neg_quo_q ? -dvd_q : dvd_q;
            remainder <= neg_rem_q ? -rem_q : rem_q;
          end
          div_by_zero <= dz_q;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
